// File: rtl/cp0_exc_unit_if.sv
// CP0 exception unit bus: mfc0/mtc0 access, M-stage exception inputs and flush request.
interface cp0_exc_unit_if;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [5:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller at M stage: SR, Cause, EPC, eret and mfc0/mtc0.
// Optional PRId register (addr 15) enabled by defining CP0_PRID_EN.
module cp0_exc_unit #(
  parameter logic [31:0] SR_RESET   = 32'h0000_0000,
  parameter logic [31:0] PRID_VALUE = 32'h0000_4350
) (
  input logic           clk,
  input logic           reset,
  cp0_exc_unit_if.slave bus
);

  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic [5:0]  ip_q;
  logic [4:0]  code_q;
  logic        bd_q;
  logic [31:0] epc_q;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr;
  logic [31:0] cause;

  always_comb begin
    int_req = ie_q & ~exl_q & (|(bus.HWInt & im_q));
    exc_req = bus.ExcCodeIn[5] & ~exl_q;
    req     = int_req | exc_req;
    wr_sr   = bus.en && (bus.CP0Add == 5'd12);
    wr_epc  = bus.en && (bus.CP0Add == 5'd14);
    sr      = {16'h0000, im_q, 8'h00, exl_q, ie_q};
    cause   = {bd_q, 15'h0000, ip_q, 3'b000, code_q, 2'b00};
  end

  assign bus.Req    = req;
  assign bus.EPCOut = epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q   <= SR_RESET[15:10];
      exl_q  <= SR_RESET[1];
      ie_q   <= SR_RESET[0];
      ip_q   <= 6'd0;
      code_q <= 5'd0;
      bd_q   <= 1'b0;
      epc_q  <= 32'd0;
    end else begin
      ip_q <= bus.HWInt;
      if (req) begin
        // Interrupt wins over a same-cycle exception and records code 0.
        exl_q  <= 1'b1;
        code_q <= int_req ? 5'd0 : bus.ExcCodeIn[4:0];
        bd_q   <= bus.BDIn;
        epc_q  <= bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
      end else begin
        if (wr_sr) begin
          im_q <= bus.CP0In[15:10];
          ie_q <= bus.CP0In[0];
        end
        // eret overrides the EXL bit of a same-edge SR write.
        if (bus.EXLClr) begin
          exl_q <= 1'b0;
        end else if (wr_sr) begin
          exl_q <= bus.CP0In[1];
        end
        if (wr_epc) begin
          epc_q <= {bus.CP0In[31:2], 2'b00};
        end
      end
    end
  end

  always_comb begin
    unique case (bus.CP0Add)
      5'd12:   bus.CP0Out = sr;
      5'd13:   bus.CP0Out = cause;
      5'd14:   bus.CP0Out = epc_q;
`ifdef CP0_PRID_EN
      5'd15:   bus.CP0Out = PRID_VALUE;
`endif
      default: bus.CP0Out = 32'h0000_0000;
    endcase
  end

  logic unused_bits;
`ifdef CP0_PRID_EN
  assign unused_bits = ^{bus.CP0In[31:16], bus.CP0In[9:2], SR_RESET[31:16], SR_RESET[9:2]};
`else
  assign unused_bits = ^{bus.CP0In[31:16], bus.CP0In[9:2], SR_RESET[31:16], SR_RESET[9:2],
                         PRID_VALUE};
`endif

endmodule
